// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the multiplexed 7-segment display: segment bit
// positions, anode polarity and the scan sequencer state type.
package seven_seg_scanner_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Common-anode display: a high anode line switches the digit off.
    localparam logic AN_OFF = 1'b1;

    typedef enum logic {
        SETTLE = 1'b0,
        ON     = 1'b1
    } state_t;

    // Places a segment pattern given as {a,b,c,d,e,f,g} into SEG bit order.
    function automatic logic [7:0] segs(input logic [6:0] abcdefg);
        logic [7:0] s;
        s         = '0;
        s[SEG_A]  = abcdefg[6];
        s[SEG_B]  = abcdefg[5];
        s[SEG_C]  = abcdefg[4];
        s[SEG_D]  = abcdefg[3];
        s[SEG_E]  = abcdefg[2];
        s[SEG_F]  = abcdefg[1];
        s[SEG_G]  = abcdefg[0];
        return s;
    endfunction

endpackage

// File: rtl/decoder_7_seg.sv
// Registered hex-nibble to 7-segment decoder (active-high segments, dp bit
// always 0); output appears one clock after D.
module decoder_7_seg
    import seven_seg_scanner_pkg::*;
(
    input  logic       CLK,
    input  logic [3:0] D,
    output logic [7:0] SEG
);

    logic [7:0] seg_d;
    logic [7:0] seg_q;

    always_comb begin
        seg_d = '0;
        unique case (D)
            4'h0: seg_d = segs(7'b1111110);
            4'h1: seg_d = segs(7'b0110000);
            4'h2: seg_d = segs(7'b1101101);
            4'h3: seg_d = segs(7'b1111001);
            4'h4: seg_d = segs(7'b0110011);
            4'h5: seg_d = segs(7'b1011011);
            4'h6: seg_d = segs(7'b1011111);
            4'h7: seg_d = segs(7'b1110000);
            4'h8: seg_d = segs(7'b1111111);
            4'h9: seg_d = segs(7'b1111011);
            4'hA: seg_d = segs(7'b1110111);
            4'hB: seg_d = segs(7'b0011111);
            4'hC: seg_d = segs(7'b1001110);
            4'hD: seg_d = segs(7'b0111101);
            4'hE: seg_d = segs(7'b1001111);
            4'hF: seg_d = segs(7'b1000111);
            default: seg_d = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        seg_q <= seg_d;
    end

    assign SEG = seg_q;

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner: per-digit nibble/dp
// register file, blank-then-on slot sequencer and one shared decoder.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 16,
    parameter int ON_CYCLES    = 2500
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          WE,
    input  logic [$clog2(NUM_DIGITS)-1:0] WADDR,
    input  logic [3:0]                    WDATA,
    input  logic                          WDP,
    input  logic [NUM_DIGITS-1:0]         EN_MASK,
    output logic [NUM_DIGITS-1:0]         AN,
    output logic [7:0]                    SEG,
    output logic                          FRAME
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int MAX_CYC = (BLANK_CYCLES > ON_CYCLES) ? BLANK_CYCLES : ON_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]  an_q, an_d;
    logic                   frame_q, frame_d;

    logic [3:0]             nib_q [NUM_DIGITS];
    logic [3:0]             nib_d [NUM_DIGITS];
    logic                   rdp_q [NUM_DIGITS];
    logic                   rdp_d [NUM_DIGITS];

    logic [3:0]             cur_nib_q, cur_nib_d;
    logic                   cur_dp_q, cur_dp_d;
    logic                   dp_dly_q, dp_dly_d;
    logic [7:0]             dec_seg;

    always_comb begin
        nib_d = nib_q;
        rdp_d = rdp_q;
        if (WE && (int'(WADDR) < NUM_DIGITS)) begin
            nib_d[WADDR] = WDATA;
            rdp_d[WADDR] = WDP;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q + 1'b1;
        frame_d   = 1'b0;
        cur_nib_d = cur_nib_q;
        cur_dp_d  = cur_dp_q;
        unique case (state_q)
            SETTLE: begin
                // Snapshot reads the pre-write register value, so a write on
                // this edge only shows on the next visit to the digit.
                if (cnt_q == '0) begin
                    cur_nib_d = nib_q[idx_q];
                    cur_dp_d  = rdp_q[idx_q];
                end
                if (cnt_q == BLANK_LAST) begin
                    state_d = ON;
                    cnt_d   = '0;
                end
            end
            ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                    idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    frame_d = (idx_q == LAST_IDX);
                end
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase

        // Disabled digits still consume their slot; only the anode stays off.
        an_d = {NUM_DIGITS{AN_OFF}};
        if ((state_d == ON) && EN_MASK[idx_d]) begin
            an_d[idx_d] = ~AN_OFF;
        end
    end

    assign dp_dly_d = cur_dp_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= SETTLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            an_q    <= {NUM_DIGITS{AN_OFF}};
            frame_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                nib_q[i] <= 4'h0;
                rdp_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            an_q    <= an_d;
            frame_q <= frame_d;
            nib_q   <= nib_d;
            rdp_q   <= rdp_d;
        end
    end

    always_ff @(posedge CLK) begin
        cur_nib_q <= cur_nib_d;
        cur_dp_q  <= cur_dp_d;
        dp_dly_q  <= dp_dly_d;
    end

    decoder_7_seg u_decoder (
        .CLK (CLK),
        .D   (cur_nib_q),
        .SEG (dec_seg)
    );

    assign SEG   = {dec_seg[7:1], dec_seg[SEG_DP] | dp_dly_q};
    assign AN    = an_q;
    assign FRAME = frame_q;

endmodule
